div_seq: RTL
============

// Module: div_seq
// PURPOSE
//  Iterative restoring divider: the subtract-based inverse of the datapath adder.
//  Accepts dividend/divisor on a start pulse and produces quotient, remainder and
//  flags after bw iterations, one iteration per clock. Sits beside the ALU adder
//  in the CPU execute stage; the sequencer stalls on busy and samples results on done.
// PARAMETERS
//  bw   8   operand/result width in bits (>=2)
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous reset, active low
//  start     in   1    request; accepted only when busy=0
//  dividend  in   bw   numerator, sampled on accepted start
//  divisor   in   bw   denominator, sampled on accepted start
//  quo       out  bw   quotient, valid from done, held until next accepted start
//  rem       out  bw   remainder, same validity as quo
//  busy      out  1    1 from cycle after accepted start until done cycle (inclusive)
//  done      out  1    one-cycle pulse: results valid
//  dz        out  1    divide-by-zero flag, valid with done
//  neg       out  1    quo[bw-1], valid with done
//  ov        out  1    signed overflow flag, valid with done (0 when unsigned build)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; quo, rem, busy, done, dz, neg, ov all 0.
//  - States: IDLE -> (start) RUN, or -> DONE directly if divisor==0;
//    RUN -> DONE after exactly bw iterations; DONE -> IDLE next cycle.
//  - Latency: start accepted at edge N -> done=1 during cycle N+bw+1; dz path
//    done during cycle N+1. done lasts one cycle; busy=0 in IDLE only.
//  - start while busy=1 is ignored (no restart, no effect on operands).
//  - start in DONE cycle ignored; start in IDLE accepted, back-to-back OK.
//  - Iteration: partial remainder P is bw+1 bits. Each cycle P={P[bw-1:0],A[bw-1]},
//    A<<=1; T=P-{1'b0,divisor}; if T[bw]==0 then P=T, A[0]=1 else A[0]=0.
//    After bw cycles quo=A, rem=P[bw-1:0].
//  - Divide by zero: dz=1, quo=all ones, rem=dividend, ov=0.
//  - Flags and quo/rem update only at DONE entry; held stable otherwise.
//  - rst_n asserted mid-operation: abort immediately, outputs to reset values,
//    no done pulse for the aborted operation.
// CONFIGURATION
//  DIV_SIGNED_EN defined: operands are two's complement. Magnitudes divided as
//   above; quo negated if operand signs differ; rem takes dividend's sign
//   (truncating division). -2^(bw-1) / -1 -> ov=1, quo=-2^(bw-1), rem=0,
//   same latency as normal. Divide by zero: quo=all ones, rem=dividend.
//  DIV_SIGNED_EN undefined: unsigned only, sign logic absent, ov tied 0.
// STRUCTURE
//  - Package div_pkg: state enum {IDLE,RUN,DONE}; iteration counter width
//    localparam CW=$clog2(bw+1).
//  - Sub-module div_step (combinational): one shift-subtract iteration,
//    inputs P, A, divisor; outputs next P, next A. Instantiated once in the
//    RUN datapath; registers, counter and FSM stay in div_seq.
// TESTING (bw=8)
//  - Unsigned 100/7 -> done 9 cycles after start, quo=14, rem=2, dz=0, ov=0.
//  - 5/0 -> done next cycle, dz=1, quo=8'hFF, rem=5.
//  - 3/10 -> quo=0, rem=3, neg=0; then back-to-back start 255/1 -> quo=255, neg=1.
//  - start re-pulsed at cycles 2..5 of an operation -> ignored, one done, result
//    of first operands; rst_n low at cycle 4 -> all outputs 0, no done.
//  - DIV_SIGNED_EN: -7/2 -> quo=8'hFD (-3), rem=8'hFF (-1); 7/-2 -> quo=-3, rem=1.
//  - DIV_SIGNED_EN: -128/-1 -> ov=1, quo=8'h80, rem=0; 
//    unsigned build of 8'h80/8'hFF -> quo=0, rem=8'h80, ov=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states and
// iteration-counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int BW_DEFAULT = 8;

  // Counter wide enough to hold every value from 0 up to the operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CW = cnt_width(BW_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
// The partial remainder carries one guard bit above the operand width.
module div_step
  import div_pkg::*;
#(
  parameter int bw = BW_DEFAULT
) (
  input  logic [bw:0]   p_in,
  input  logic [bw-1:0] a_in,
  input  logic [bw-1:0] divisor,
  output logic [bw:0]   p_out,
  output logic [bw-1:0] a_out
);

  logic [bw:0] shifted;
  logic [bw:0] trial;
  logic        unused_guard;

  // The guard bit of the incoming remainder is always clear after a restore,
  // so it is shifted out without being looked at.
  assign unused_guard = p_in[bw];

  // Shift the next dividend bit in, trial-subtract, keep the difference if it did not borrow.
  always_comb begin
    shifted = {p_in[bw-1:0], a_in[bw-1]};
    trial   = shifted - {1'b0, divisor};
    p_out   = shifted;
    a_out   = {a_in[bw-2:0], 1'b0};
    if (!trial[bw]) begin
      p_out = trial;
      a_out = {a_in[bw-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Optional build macro: DIV_SIGNED_EN selects two's-complement operands
// (truncating division, signed overflow flag); undefined gives an unsigned divider.
module div_seq
  import div_pkg::*;
#(
  parameter int bw = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [bw-1:0] dividend,
  input  logic [bw-1:0] divisor,
  output logic [bw-1:0] quo,
  output logic [bw-1:0] rem,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          neg,
  output logic          ov
);

  localparam int cw = cnt_width(bw);

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          last_iter;
  logic [bw:0]   p_reg;
  logic [bw:0]   p_next;
  logic [bw-1:0] a_reg;
  logic [bw-1:0] a_next;
  logic [bw-1:0] dsr_reg;
  logic [cw-1:0] cnt;
  logic [bw-1:0] dividend_mag;
  logic [bw-1:0] divisor_mag;
  logic [bw-1:0] quo_fin;
  logic [bw-1:0] rem_fin;
  logic          ov_fin;

`ifdef DIV_SIGNED_EN
  logic          quo_sign;
  logic          rem_sign;
`endif

  div_step #(.bw(bw)) u_step (
    .p_in    (p_reg),
    .a_in    (a_reg),
    .divisor (dsr_reg),
    .p_out   (p_next),
    .a_out   (a_next)
  );

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic plus the handshake outputs decoded from the current state.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == cw'(bw - 1)) begin
          last_iter  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef DIV_SIGNED_EN
  // Divide magnitudes, then restore signs: quotient negative when signs differ,
  // remainder follows the dividend. Only -2^(bw-1)/-1 yields a positive quotient with the top bit set.
  always_comb begin
    dividend_mag = dividend[bw-1] ? -dividend : dividend;
    divisor_mag  = divisor[bw-1]  ? -divisor  : divisor;
    quo_fin      = quo_sign ? -a_next : a_next;
    rem_fin      = rem_sign ? -p_next[bw-1:0] : p_next[bw-1:0];
    ov_fin       = !quo_sign && a_next[bw-1];
  end
`else
  // Unsigned operands go straight into the datapath; overflow cannot occur.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    quo_fin      = a_next;
    rem_fin      = p_next[bw-1:0];
    ov_fin       = 1'b0;
  end
`endif

  // Operand capture, iteration registers and result/flag registers that change only on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      a_reg   <= '0;
      dsr_reg <= '0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dz      <= 1'b0;
      neg     <= 1'b0;
      ov      <= 1'b0;
`ifdef DIV_SIGNED_EN
      quo_sign <= 1'b0;
      rem_sign <= 1'b0;
`endif
    end else if (accept) begin
      p_reg   <= '0;
      a_reg   <= dividend_mag;
      dsr_reg <= divisor_mag;
      cnt     <= '0;
`ifdef DIV_SIGNED_EN
      quo_sign <= dividend[bw-1] ^ divisor[bw-1];
      rem_sign <= dividend[bw-1];
`endif
      if (divisor == '0) begin
        quo <= '1;
        rem <= dividend;
        dz  <= 1'b1;
        neg <= 1'b1;
        ov  <= 1'b0;
      end
    end else if (state == RUN) begin
      p_reg <= p_next;
      a_reg <= a_next;
      cnt   <= cnt + cw'(1);
      if (last_iter) begin
        quo <= quo_fin;
        rem <= rem_fin;
        dz  <= 1'b0;
        neg <= quo_fin[bw-1];
        ov  <= ov_fin;
      end
    end
  end

endmodule
